b08_driver: RTL and testbench

B08_DRIVER -- requirements
Module: b08_driver

---
 rtl/b08_driver.sv | 124 ++++++++++++
 tb/tb_b08_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/b08_driver.sv
// Sweep driver for the b08 benchmark circuit: launches each stimulus value, waits for the
// result, and folds every sampled O_IN into a rotating signature and a non-zero counter.
module b08_driver #(
  parameter int unsigned WAIT_CYC  = 17,
  parameter int unsigned DRAIN_CYC = 18
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       GO,
  input  logic [7:0] FIRST,
  input  logic [7:0] LAST,
  input  logic [3:0] O_IN,
  output logic       START,
  output logic [7:0] I,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] SIG,
  output logic [3:0] LAST_O,
  output logic [8:0] NZ_CNT
);

  typedef enum logic [2:0] {
    StDrain,
    StIdle,
    StLaunch,
    StHold,
    StSample
  } state_e;

  localparam logic [7:0] HoldEnd  = 8'(WAIT_CYC - 1);
  localparam logic [7:0] DrainEnd = 8'(DRAIN_CYC - 1);

  state_e     r_state;
  state_e     w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] r_cur;
  logic [7:0] r_last;
  logic [7:0] r_sig;
  logic [3:0] r_last_o;
  logic [8:0] r_nz;
  logic       r_done;
  logic       w_accept;
  logic       w_sweep_end;

  assign w_accept    = (r_state == StIdle) && GO;
  assign w_sweep_end = (r_cur == r_last);

  // State register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= StDrain;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StDrain:  if (r_cnt == DrainEnd) w_state_next = StIdle;
      StIdle:   if (GO) w_state_next = StLaunch;
      StLaunch: w_state_next = StHold;
      StHold:   if (r_cnt == HoldEnd) w_state_next = StSample;
      StSample: w_state_next = w_sweep_end ? StIdle : StLaunch;
      default:  w_state_next = StDrain;
    endcase
  end

  // Outputs
  always_comb begin
    START  = (r_state == StLaunch);
    BUSY   = (r_state != StIdle);
    I      = r_cur;
    DONE   = r_done;
    SIG    = r_sig;
    LAST_O = r_last_o;
    NZ_CNT = r_nz;
  end

  // Cycle counter restarts on every state change, so DRAIN and HOLD both count from zero.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= 8'd0;
    end else if (w_state_next != r_state) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_cur  <= 8'h00;
      r_last <= 8'h00;
    end else if (w_accept) begin
      r_cur  <= FIRST;
      r_last <= LAST;
    end else if ((r_state == StSample) && !w_sweep_end) begin
      r_cur <= r_cur + 8'd1;
    end
  end

  // Results land on the same edge that leaves SAMPLE, so DONE and the final values coincide.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_sig    <= 8'h00;
      r_last_o <= 4'h0;
      r_nz     <= 9'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == StSample) && w_sweep_end;
      if (w_accept) begin
        r_sig <= 8'h00;
        r_nz  <= 9'd0;
      end else if (r_state == StSample) begin
        r_last_o <= O_IN;
        r_sig    <= {r_sig[6:0], r_sig[7]} ^ {4'b0000, O_IN};
        if (O_IN != 4'h0) r_nz <= r_nz + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_b08_driver.sv
// Directed bench for b08_driver; O_IN comes from a small stand-in for the b08 response.
module tb_b08_driver;

  logic       clk;
  logic       rst;
  logic       go;
  logic [7:0] first;
  logic [7:0] last;
  logic [3:0] o_in;
  logic       start;
  logic [7:0] i_bus;
  logic       busy;
  logic       done;
  logic [7:0] sig;
  logic [3:0] last_o;
  logic [8:0] nz_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  int         start_cnt = 0;
  int         done_cnt  = 0;
  int         start_dbl = 0;
  int         i_bad     = 0;
  logic       prev_start = 1'b0;
  logic [7:0] prev_i     = 8'h00;
  logic [7:0] lq[$];

  logic       zero_en = 1'b0;
  logic [7:0] zero_at = 8'h00;

  b08_driver dut (
    .CLOCK  (clk),
    .RESET  (rst),
    .GO     (go),
    .FIRST  (first),
    .LAST   (last),
    .O_IN   (o_in),
    .START  (start),
    .I      (i_bus),
    .BUSY   (busy),
    .DONE   (done),
    .SIG    (sig),
    .LAST_O (last_o),
    .NZ_CNT (nz_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in response: b08(0x00)=0xF, b08(0xFF)=0xE, never zero unless forced.
  function automatic logic [3:0] b08_model(input logic [7:0] v);
    if (v[7]) return 4'hF ^ {3'b000, v[0]};
    return 4'hF ^ {v[5], v[3], v[1], 1'b0};
  endfunction

  assign o_in = (zero_en && (i_bus == zero_at)) ? 4'h0 : b08_model(i_bus);

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (start) begin
        start_cnt++;
        lq.push_back(i_bus);
        if (prev_start) start_dbl++;
      end
      if (done) done_cnt++;
      if ((i_bus !== prev_i) && !start) i_bad++;
    end
    prev_start = start;
    prev_i     = i_bus;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic launch(input logic [7:0] f, input logic [7:0] l);
    first = f;
    last  = l;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    while ((done !== 1'b1) && (cyc < bound)) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    int         bad;
    logic [7:0] exp_sig;

    rst   = 1'b1;
    go    = 1'b1;
    first = 8'h00;
    last  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_start", 16'(start), 16'h0);
    chk("rst_i", 16'(i_bus), 16'h00);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_sig", 16'(sig), 16'h00);
    chk("rst_last_o", 16'(last_o), 16'h0);
    chk("rst_nz", 16'(nz_cnt), 16'h0);
    chk("rst_busy", 16'(busy), 16'h1);

    // Drain with GO held high, then the first sweep 0x00..0x00.
    start_cnt = 0;
    done_cnt  = 0;
    rst = 1'b0;
    bad = 0;
    repeat (17) begin
      @(negedge clk);
      if ((busy !== 1'b1) || (start !== 1'b0)) bad++;
    end
    chk("drain_busy_nostart", 16'(bad), 16'h0);
    @(negedge clk);
    chk("idle_after_drain_busy", 16'(busy), 16'h0);
    chk("idle_after_drain_start", 16'(start), 16'h0);
    @(negedge clk);
    chk("first_launch_start", 16'(start), 16'h1);
    go = 1'b0;
    wait_done(60, cyc);
    chk("p1_done_lat", 16'(cyc), 16'd19);
    chk("p1_last_o", 16'(last_o), 16'hF);
    chk("p1_sig", 16'(sig), 16'h0F);
    chk("p1_nz", 16'(nz_cnt), 16'd1);
    chk("p1_busy", 16'(busy), 16'h0);
    @(negedge clk);
    chk("p1_done_pulse", 16'(done), 16'h0);
    chk("p1_sig_hold", 16'(sig), 16'h0F);

    // Wrapping sweep 0xFF..0x00.
    start_cnt = 0;
    lq.delete();
    launch(8'hFF, 8'h00);
    wait_done(100, cyc);
    chk("wrap_done_lat", 16'(cyc), 16'd38);
    chk("wrap_last_o", 16'(last_o), 16'hF);
    chk("wrap_sig", 16'(sig), 16'h13);
    chk("wrap_nz", 16'(nz_cnt), 16'd2);
    chk("wrap_starts", 16'(start_cnt), 16'd2);
    chk("wrap_qsize", 16'(lq.size()), 16'd2);
    if (lq.size() == 2) begin
      chk("wrap_i0", 16'(lq[0]), 16'hFF);
      chk("wrap_i1", 16'(lq[1]), 16'h00);
    end

    // GO pulse during HOLD is ignored; one zero result in the middle point.
    start_cnt = 0;
    done_cnt  = 0;
    lq.delete();
    zero_en = 1'b1;
    zero_at = 8'h11;
    launch(8'h10, 8'h12);
    repeat (3) @(negedge clk);
    go    = 1'b1;
    first = 8'h80;
    last  = 8'h80;
    @(negedge clk);
    go = 1'b0;
    wait_done(100, cyc);
    chk("gohold_done_lat", 16'(cyc + 4), 16'd57);
    chk("gohold_sig", 16'(sig), 16'h31);
    chk("gohold_last_o", 16'(last_o), 16'hD);
    chk("gohold_nz", 16'(nz_cnt), 16'd2);
    chk("gohold_starts", 16'(start_cnt), 16'd3);
    if (lq.size() == 3) chk("gohold_i1", 16'(lq[1]), 16'h11);
    repeat (25) @(negedge clk);
    chk("gohold_done_cnt", 16'(done_cnt), 16'd1);
    chk("gohold_idle", 16'(busy), 16'h0);
    zero_en = 1'b0;

    // Reset in the fifth HOLD cycle.
    done_cnt = 0;
    launch(8'h20, 8'h30);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_start", 16'(start), 16'h0);
    chk("midrst_i", 16'(i_bus), 16'h00);
    chk("midrst_done", 16'(done), 16'h0);
    chk("midrst_sig", 16'(sig), 16'h00);
    chk("midrst_last_o", 16'(last_o), 16'h0);
    chk("midrst_nz", 16'(nz_cnt), 16'h0);
    chk("midrst_busy", 16'(busy), 16'h1);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while ((busy !== 1'b0) && (cyc < 40)) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_drain_len", 16'(cyc), 16'd18);
    chk("midrst_no_done", 16'(done_cnt), 16'd0);
    launch(8'hFF, 8'hFF);
    wait_done(60, cyc);
    chk("post_rst_lat", 16'(cyc), 16'd19);
    chk("post_rst_last_o", 16'(last_o), 16'hE);
    chk("post_rst_sig", 16'(sig), 16'h0E);
    chk("post_rst_nz", 16'(nz_cnt), 16'd1);

    // Full 256-point sweep.
    exp_sig = 8'h00;
    for (int k = 0; k < 256; k++) begin
      exp_sig = {exp_sig[6:0], exp_sig[7]} ^ {4'b0000, b08_model(8'(k))};
    end
    start_cnt = 0;
    done_cnt  = 0;
    launch(8'h00, 8'hFF);
    wait_done(6000, cyc);
    chk("full_done_lat", 16'(cyc), 16'd4864);
    chk("full_nz", 16'(nz_cnt), 16'h100);
    chk("full_starts", 16'(start_cnt), 16'd256);
    chk("full_last_o", 16'(last_o), 16'hE);
    chk("full_sig", 16'(sig), 16'(exp_sig));
    repeat (5) @(negedge clk);
    chk("full_done_cnt", 16'(done_cnt), 16'd1);
    chk("start_never_double", 16'(start_dbl), 16'd0);
    chk("i_stable_outside_launch", 16'(i_bad), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
